fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control decoder and datapath. It owns the fetch PC and issues word reads to a variable-latency instruction memory over a valid/ready request channel and a valid response channel.
- Returned words are buffered in a small in-order queue. They are presented to decode as (instr, pc) pairs over a valid/ready handshake.
- Branch/jump redirects from the datapath flush all queued and in-flight fetches.

Parameters:
- DEPTH, 4: queue entries; also the maximum number of in-flight requests (power of two, >=2).
- RESET_PC, 32'h0000_0000: fetch and decode PC after reset.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  imem accepts request this cycle
- imem_req_addr  output  32  word-aligned fetch address
- imem_resp_valid  input  1  read data returned (in request order, at most one per cycle)
- imem_resp_data  input  32  instruction word
- dec_valid  output  1  dec_instr/dec_pc valid
- dec_ready  input  1  decode consumes head this cycle
- dec_instr  output  32  instruction at queue head
- dec_pc  output  32  address of dec_instr
- redirect  input  1  taken branch/jump; flush and restart
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (forced 00)

Behaviour:
- Reset (async, while asserted):
  - fetch_pc = RESET_PC, head_pc = RESET_PC.
  - Queue empty; outstanding = 0; drop_cnt = 0.
  - imem_req_valid = 0, dec_valid = 0, imem_req_addr = RESET_PC, dec_pc = RESET_PC.
- Issue:
  - imem_req_valid = 1 when (queue count + outstanding) < DEPTH and no redirect this cycle. Credits are reserved at issue, so a response can never overflow the queue.
  - imem_req_addr = fetch_pc.
  - On accept (valid & ready): fetch_pc += 4 (mod 2^32 wrap), outstanding += 1.
  - Valid and addr hold stable until accepted, except when a redirect occurs.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt > 0, the data is discarded and drop_cnt -= 1. Otherwise the word is pushed to the queue tail.
  - Pushed data is visible to decode the next cycle; there is no combinational bypass.
  - Minimum latency: request accepted in cycle N, response in N+1, dec_valid in N+2.
- Decode:
  - dec_valid = queue non-empty; dec_instr = head entry; dec_pc = head_pc.
  - Pop on dec_valid & dec_ready; head_pc += 4.
  - Simultaneous push and pop at any occupancy is legal; the count is unchanged.
- Redirect (wins over everything in the same cycle):
  - Queue cleared; any pop that cycle is ignored.
  - fetch_pc = head_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding + (request accepted this cycle) - (response this cycle).
  - A response arriving in the redirect cycle is discarded.
  - imem_req_valid = 0 in the redirect cycle; fetching resumes at the new PC the next cycle.
  - Back-to-back redirects re-accumulate drop_cnt correctly; drop_cnt never exceeds DEPTH.
- Reset mid-operation: all state returns to reset values immediately. Responses to pre-reset requests are the imem's responsibility (imem is reset with the same signal).
- Invariants: queue count + outstanding <= DEPTH; drop_cnt <= outstanding.
- X-safety: imem_resp_data is never written to the queue when imem_resp_valid = 0.

Decomposition:
- Shared package mips_pkg:
  - ADDR_W = 32 and INSTR_W = 32.
  - WORD_BYTES = 4 (PC increment).
  - RESET_PC default value.
- Sub-module fetch_fifo:
  - Synchronous FIFO parameterised by DEPTH and WIDTH with push, pop, clear, empty, count.
  - Circular pointers with an extra wrap bit.
  - fetch_unit contains the PC, credit and drop-counter logic.

Test Plan:
- Zero-wait imem (ready = 1, response 1 cycle later), dec_ready = 1 → after reset release, dec_pc sequence 0, 4, 8, 12…; one instruction per cycle steady state; first dec_valid 2 cycles after first accept.
- dec_ready = 0 for 10 cycles → exactly DEPTH = 4 requests issued (0, 4, 8, 12), then imem_req_valid = 0. Releasing dec_ready drains 0..12 in order, and fetching resumes at 16.
- imem_req_ready toggling with 3-cycle response latency → imem_req_addr stable while valid & !ready; no duplicated or skipped PCs at decode.
- Redirect to 0x40 with 2 requests in flight and 1 queued entry → queue flushed; both stale responses dropped; next decode output is pc 0x40; next requests are 0x40, 0x44.
- Redirect with redirect_pc = 0x83 in the same cycle as a response and a dec pop → response dropped, pop ignored, fetch restarts at 0x80.
- Assert reset mid-stream with a full queue → dec_valid = 0 and imem_req_valid = 0 immediately. After release, fetch restarts at RESET_PC and no stale words are ever delivered.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared widths and constants for the MIPS front end.
//               ADDR_W / INSTR_W : address and instruction widths
//               WORD_BYTES       : PC step between sequential instructions
//               RESET_PC_DEFAULT : default fetch PC after reset
//               word_align()     : clears the byte-offset bits of an address
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int ADDR_W     = 32;
    localparam int INSTR_W    = 32;
    localparam int WORD_BYTES = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Instructions are always word aligned, so the low two bits of any
    // externally supplied target are meaningless and forced to zero.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(WORD_BYTES - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous in-order FIFO holding fetched instruction words.
//               Circular read/write pointers carry an extra wrap bit so that
//               full and empty are distinguishable at equal indices.
// Ports       : clk, reset      - clock, async active-high reset
//               push, push_data - write one entry at the tail
//               pop             - drop the head entry (ignored when empty)
//               clear           - discard all entries (wins over push/pop)
//               head_data       - entry at the head
//               empty, count    - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       head_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   r_wr_ptr;
    logic [PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_do_push;
    logic w_do_pop;

    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign count  = r_wr_ptr - r_rd_ptr;

    // A push into a full FIFO is accepted when the head leaves in the same
    // cycle: the slot being written is the one being vacated.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!w_full || w_do_pop);

    assign head_data = r_mem[r_rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !clear) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Owns the fetch PC, issues word reads
//               to a variable-latency instruction memory, buffers returned
//               words in order and hands (instr, pc) pairs to decode.
//               Redirects flush queued words and drop in-flight responses.
// Ports       : clk, reset                         - clock, async reset
//               imem_req_valid/ready/addr          - fetch request channel
//               imem_resp_valid/data               - in-order read returns
//               dec_valid/ready, dec_instr/dec_pc  - decode handshake
//               redirect, redirect_pc              - taken branch/jump
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import mips_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   c_depth = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] c_step = ADDR_W'(WORD_BYTES);

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_head_pc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_drop_cnt;

    logic [CW-1:0]     w_fifo_count;
    logic              w_fifo_empty;
    logic [CW:0]       w_inflight;
    logic              w_credit_ok;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_dropping;
    logic [CW-1:0]     w_outstanding_nxt;
    logic [ADDR_W-1:0] w_target_pc;

    // Credits are reserved at issue time: queued words plus requests still in
    // flight never exceed the queue depth, so every response has a slot.
    assign w_inflight  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_credit_ok = (w_inflight < {1'b0, c_depth});

    assign imem_req_valid = !reset && !redirect && w_credit_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_accept       = imem_req_valid && imem_req_ready;

    assign w_outstanding_nxt = r_outstanding + CW'(w_accept) - CW'(imem_resp_valid);

    // Responses belonging to requests issued before a redirect are discarded
    // while the drop counter is non-zero, as is any response in the redirect
    // cycle itself.
    assign w_dropping = (r_drop_cnt != '0);
    assign w_push     = imem_resp_valid && !w_dropping && !redirect;
    assign w_pop      = !w_fifo_empty && dec_ready && !redirect;

    assign w_target_pc = word_align(redirect_pc);

    assign dec_valid = !w_fifo_empty;
    assign dec_pc    = r_head_pc;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (imem_resp_data),
        .pop       (w_pop),
        .clear     (redirect),
        .head_data (dec_instr),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_head_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (redirect) begin
                r_fetch_pc <= w_target_pc;
                r_head_pc  <= w_target_pc;
                // Everything still in flight after this edge is stale.
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + c_step;
                end
                if (w_pop) begin
                    r_head_pc <= r_head_pc + c_step;
                end
                if (imem_resp_valid && w_dropping) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit. A behavioural instruction
//               memory answers requests in order after a programmable
//               latency; expected decode (pc, instr) pairs are queued by the
//               directed tests and checked by a monitor on each decode pop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    pend_t       p;
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lat = 1;
    int acc_total = 0;
    int resp_total = 0;
    int req_stop = BIG;
    int resp_stop = BIG;
    bit ready_toggle = 1'b0;

    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    int first_acc_cyc = -1;
    int first_dv_cyc  = -1;
    int first_pop_cyc = -1;
    int last_pop_cyc  = -1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hFFFF_FFFF;
    endfunction

    // Instruction memory model plus request/decode monitors in one process.
    always begin
        @(posedge clk);
        cyc++;
        #1;
        imem_req_ready = (acc_total < req_stop) && (!ready_toggle || (cyc % 3 != 1));
        if (reset) begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end else if (pend_q.size() != 0 && pend_q[0].due <= cyc && resp_total < resp_stop) begin
            p = pend_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(p.addr);
            resp_total++;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
        end

        @(negedge clk);
        if (reset) begin
            pend_q.delete();
            prev_hold     = 1'b0;
            first_acc_cyc = -1;
            first_dv_cyc  = -1;
            first_pop_cyc = -1;
            last_pop_cyc  = -1;
        end else begin
            if (prev_hold && !redirect) begin
                check("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
                check("req_hold_addr", imem_req_addr, prev_addr);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr_aligned", {30'd0, imem_req_addr[1:0]}, 32'd0);
                p.addr = imem_req_addr;
                p.due  = cyc + lat;
                pend_q.push_back(p);
                acc_log.push_back(imem_req_addr);
                acc_total++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            prev_hold = imem_req_valid && !imem_req_ready;
            prev_addr = imem_req_addr;

            if (dec_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
            if (dec_valid && dec_ready && !redirect) begin
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("dec_unexpected_pc", dec_pc, 32'hFFFF_FFFF);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("dec_pc", dec_pc, e);
                    check("dec_instr", dec_instr, instr_of(e));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = '0;
        dec_ready    = 1'b0;
        lat          = 1;
        ready_toggle = 1'b0;
        req_stop     = BIG;
        resp_stop    = BIG;
        tick(2);
        exp_q.delete();
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            check(name, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark;
        reset           = 1'b1;
        dec_ready       = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick(2);

        // Reset state
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_dec_pc", dec_pc, 32'h0);

        // Zero-wait memory, decode always ready
        apply_reset();
        dec_ready = 1'b1;
        reset     = 1'b0;
        push_seq(32'h0, 8);
        wait_drain("t1_drain", 100);
        dec_ready = 1'b0;
        check("t1_first_latency", 32'(first_dv_cyc - first_acc_cyc), 32'd2);
        check("t1_pop_rate", 32'(last_pop_cyc - first_pop_cyc), 32'd7);

        // Decode stalled: exactly DEPTH requests then issue stops
        apply_reset();
        mark  = acc_log.size();
        reset = 1'b0;
        tick(10);
        check("t2_issued", 32'(acc_log.size() - mark), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_req_addr", acc_at(mark + i), 32'(4 * i));
        check("t2_req_valid_off", {31'd0, imem_req_valid}, 32'd0);
        push_seq(32'h0, 8);
        dec_ready = 1'b1;
        wait_drain("t2_drain", 100);
        dec_ready = 1'b0;
        check("t2_resume_addr", acc_at(mark + 4), 32'd16);

        // Toggling ready, 3-cycle latency
        apply_reset();
        mark         = acc_log.size();
        lat          = 3;
        ready_toggle = 1'b1;
        dec_ready    = 1'b1;
        reset        = 1'b0;
        push_seq(32'h0, 12);
        wait_drain("t3_drain", 300);
        dec_ready    = 1'b0;
        ready_toggle = 1'b0;
        for (int i = 0; i < 12; i++) check("t3_req_addr", acc_at(mark + i), 32'(4 * i));

        // Redirect with two in flight and one queued
        apply_reset();
        req_stop  = acc_total + 3;
        resp_stop = resp_total;
        reset     = 1'b0;
        tick(6);
        resp_stop = resp_total + 1;
        tick(3);
        check("t4_pre_dec_valid", {31'd0, dec_valid}, 32'd1);
        check("t4_pre_dec_pc", dec_pc, 32'h0);
        check("t4_pre_req_addr", imem_req_addr, 32'hC);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        #1;
        check("t4_redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
        tick(1);
        redirect  = 1'b0;
        mark      = acc_log.size();
        req_stop  = BIG;
        resp_stop = BIG;
        dec_ready = 1'b1;
        push_seq(32'h40, 4);
        wait_drain("t4_drain", 100);
        dec_ready = 1'b0;
        check("t4_req0", acc_at(mark), 32'h40);
        check("t4_req1", acc_at(mark + 1), 32'h44);

        // Redirect coinciding with a response and a decode pop
        apply_reset();
        req_stop  = acc_total + 2;
        resp_stop = resp_total;
        reset     = 1'b0;
        tick(5);
        resp_stop = resp_total + 1;
        tick(3);
        resp_stop = resp_total + 1;
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 32'h83;
        dec_ready   = 1'b1;
        #1;
        check("t5_redirect_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("t5_pop_offered", {31'd0, dec_valid}, 32'd1);
        tick(1);
        redirect  = 1'b0;
        mark      = acc_log.size();
        req_stop  = BIG;
        resp_stop = BIG;
        push_seq(32'h80, 4);
        wait_drain("t5_drain", 100);
        dec_ready = 1'b0;
        check("t5_req0", acc_at(mark), 32'h80);
        check("t5_req1", acc_at(mark + 1), 32'h84);

        // Reset with a full queue of words from another region
        apply_reset();
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick(1);
        redirect = 1'b0;
        tick(10);
        check("t6_full_dec_valid", {31'd0, dec_valid}, 32'd1);
        check("t6_full_dec_pc", dec_pc, 32'h200);
        reset = 1'b1;
        #1;
        check("t6_rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check("t6_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("t6_rst_dec_pc", dec_pc, 32'h0);
        tick(2);
        mark      = acc_log.size();
        dec_ready = 1'b1;
        reset     = 1'b0;
        push_seq(32'h0, 4);
        wait_drain("t6_drain", 100);
        dec_ready = 1'b0;
        check("t6_req0", acc_at(mark), 32'h0);

        tick(3);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
